// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX FIFO from NUM_SRC AXI-stream sources.
// Frames longer than MAX_BEATS are cut short, flagged bad, and their remaining beats are discarded.
module eth_tx_frame_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int AXIS_KEEP_WIDTH = 1,
  parameter int MAX_BEATS       = 1518,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                               logic_clk,
  input  logic                               logic_rst_n,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                 s_axis_tvalid,
  output logic [NUM_SRC-1:0]                 s_axis_tready,
  input  logic [NUM_SRC-1:0]                 s_axis_tlast,
  input  logic [NUM_SRC-1:0]                 s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tuser,
  input  logic                               tx_enable,
  output logic [$clog2(NUM_SRC)-1:0]         grant,
  output logic                               busy,
  output logic [COUNT_WIDTH-1:0]             frame_count,
  output logic [COUNT_WIDTH-1:0]             abort_count
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [GW-1:0] LAST_SRC  = GW'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;

  logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] sel_tkeep;
  logic                       sel_tvalid;
  logic                       sel_tlast;
  logic                       sel_tuser;
  logic [NUM_SRC-1:0]         grant_onehot;
  logic [NUM_SRC-1:0]         rot_valid;
  logic [GW-1:0]              rr_next;
  logic [GW-1:0]              grant_inc;
  logic                       xfer;
  logic                       at_limit;

  // NOTE: every signal assigned in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == GW'(i)) begin
        sel_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_tkeep  = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tuser  = s_axis_tuser[i];
      end
    end
  end

  // Rotate the valid vector so bit 0 is rr_ptr; the first set bit is the next winner.
  always_comb begin
    int sum;
    rot_valid = NUM_SRC'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr);
    rr_next   = rr_ptr;
    sum       = 0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      if (rot_valid[off]) begin
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        rr_next = GW'(sum);
      end
    end
  end

  assign grant_onehot = NUM_SRC'(1) << grant;
  assign grant_inc    = (grant == LAST_SRC) ? '0 : grant + 1'b1;
  assign at_limit     = (beat_cnt == LAST_BEAT);
  assign xfer         = m_axis_tvalid && m_axis_tready;
  assign busy         = (state != IDLE);
  assign m_axis_tdata = sel_tdata;
  assign m_axis_tkeep = sel_tkeep;

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state)
      PASS: begin
        m_axis_tvalid = sel_tvalid;
        m_axis_tlast  = sel_tlast || at_limit;
        m_axis_tuser  = sel_tuser || (at_limit && !sel_tlast);
        s_axis_tready = grant_onehot & {NUM_SRC{m_axis_tready}};
      end
      DROP:    s_axis_tready = grant_onehot;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat_cnt    <= '0;
      frame_count <= '0;
      abort_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_enable && |s_axis_tvalid) begin
            grant    <= rr_next;
            beat_cnt <= '0;
            state    <= PASS;
          end
        end
        PASS: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (sel_tlast) begin
              frame_count <= frame_count + 1'b1;
              rr_ptr      <= grant_inc;
              state       <= IDLE;
            end else if (at_limit) begin
              abort_count <= abort_count + 1'b1;
              rr_ptr      <= grant_inc;
              state       <= DROP;
            end
          end
        end
        DROP: begin
          if (sel_tvalid && sel_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
